// File: rtl/logic_unit_pipe_if.sv
// rtl/logic_unit_pipe_if.sv - operand/result handshake bundle for logic_unit_pipe
interface logic_unit_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  localparam int PW = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             ones;
  logic [PW-1:0]    popcnt;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, y, zero, ones, popcnt, match_cnt
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, y, zero, ones, popcnt, match_cnt
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - two-stage bitwise logic unit with result flags and match counter
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  logic_unit_pipe_if.slave    bus
);
  localparam int PW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_XNOR = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_NOTA = 3'd6;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [PW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + PW'(v[i]);
    return c;
  endfunction

  logic             s1_v_q, s1_v_d;
  logic [WIDTH-1:0] y1_q, y1_d;
  logic [2:0]       op1_q, op1_d;
  logic             s2_v_q, s2_v_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic             ones_q, ones_d;
  logic [PW-1:0]    popcnt_q, popcnt_d;
  logic             is_xnor_q, is_xnor_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

  logic             s1_load, s2_load, out_fire;
  logic [WIDTH-1:0] op_res;

  always_comb begin
    case (bus.op)
      OP_AND:  op_res = bus.a & bus.b;
      OP_OR:   op_res = bus.a | bus.b;
      OP_XOR:  op_res = bus.a ^ bus.b;
      OP_XNOR: op_res = ~(bus.a ^ bus.b);
      OP_NAND: op_res = ~(bus.a & bus.b);
      OP_NOR:  op_res = ~(bus.a | bus.b);
      OP_NOTA: op_res = ~bus.a;
      default: op_res = bus.a;
    endcase
  end

  // Only out_ready feeds the load chain, so in_ready never depends on the operands.
  always_comb begin
    s2_load  = !s2_v_q || bus.out_ready;
    s1_load  = !s1_v_q || s2_load;
    out_fire = s2_v_q && bus.out_ready;
  end

  always_comb begin
    s1_v_d = s1_v_q;
    y1_d   = y1_q;
    op1_d  = op1_q;
    if (s1_load) begin
      s1_v_d = bus.in_valid;
      if (bus.in_valid) begin
        y1_d  = op_res;
        op1_d = bus.op;
      end
    end
  end

  always_comb begin
    s2_v_d    = s2_v_q;
    y_d       = y_q;
    zero_d    = zero_q;
    ones_d    = ones_q;
    popcnt_d  = popcnt_q;
    is_xnor_d = is_xnor_q;
    if (s2_load) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        y_d       = y1_q;
        zero_d    = ~|y1_q;
        ones_d    = &y1_q;
        popcnt_d  = popcount(y1_q);
        is_xnor_d = (op1_q == OP_XNOR);
      end
    end
  end

  always_comb begin
    match_cnt_d = match_cnt_q;
    if (clr) begin
      match_cnt_d = '0;
    end else if (out_fire && is_xnor_q && ones_q && match_cnt_q != CNT_MAX) begin
      match_cnt_d = match_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q      <= 1'b0;
      y1_q        <= '0;
      op1_q       <= '0;
      s2_v_q      <= 1'b0;
      y_q         <= '0;
      zero_q      <= 1'b1;
      ones_q      <= 1'b0;
      popcnt_q    <= '0;
      is_xnor_q   <= 1'b0;
      match_cnt_q <= '0;
    end else begin
      s1_v_q      <= s1_v_d;
      y1_q        <= y1_d;
      op1_q       <= op1_d;
      s2_v_q      <= s2_v_d;
      y_q         <= y_d;
      zero_q      <= zero_d;
      ones_q      <= ones_d;
      popcnt_q    <= popcnt_d;
      is_xnor_q   <= is_xnor_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  assign bus.in_ready  = s1_load;
  assign bus.out_valid = s2_v_q;
  assign bus.y         = y_q;
  assign bus.zero      = zero_q;
  assign bus.ones      = ones_q;
  assign bus.popcnt    = popcnt_q;
  assign bus.match_cnt = match_cnt_q;
endmodule
